lcd_12864b_reader: RTL and testbench

Read-side bus controller for the 12864B (ST7920) 8-bit parallel LCD interface. It performs busy-flag/address-counter reads (RS=0, RW=1) and display-RAM data reads (RS=1, RW=1), generating the E strobe with programmable setup, pulse and hold counts. It samples the LCD data bus and returns the byte to the requester. It sits beside the existing write-side LCD controller on the same pins, and the top level multiplexes `rs/rw/e` while one side is idle.

---
 rtl/lcd_12864b_pkg.sv | 41 ++++
 rtl/lcd_12864b_rd_if.sv | 25 ++
 rtl/lcd_12864b_strobe.sv | 28 ++
 rtl/lcd_12864b_reader.sv | 191 +++++++++++++++++++
 tb/tb_lcd_12864b_reader.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_12864b_pkg.sv
// Shared types and timing defaults for the 12864B (ST7920) read/write controllers.
// Optional busy polling is enabled by LCD_BUSY_POLL_EN.
package lcd_12864b_pkg;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    localparam int DEF_TAS       = 2;
    localparam int DEF_TPW       = 8;
    localparam int DEF_THOLD     = 2;
    localparam int DEF_MAX_POLLS = 255;
    localparam int DEF_POLL_GAP  = 4;

`ifdef LCD_BUSY_POLL_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } t_rd_state;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } t_rd_state;
`endif

    // Counter width able to hold the largest (count - 1) among the timing parameters.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/lcd_12864b_rd_if.sv
// Requester-side handshake of the 12864B read controller.
// poll/timeout exist only when LCD_BUSY_POLL_EN is defined.
interface lcd_12864b_rd_if;
    logic       req;
    logic       rs_sel;
    logic       ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       bf;
    logic [6:0] ac;
`ifdef LCD_BUSY_POLL_EN
    logic       poll;
    logic       timeout;

    modport master (output req, rs_sel, poll,
                    input  ready, rd_valid, rd_data, bf, ac, timeout);
    modport slave  (input  req, rs_sel, poll,
                    output ready, rd_valid, rd_data, bf, ac, timeout);
`else
    modport master (output req, rs_sel,
                    input  ready, rd_valid, rd_data, bf, ac);
    modport slave  (input  req, rs_sel,
                    output ready, rd_valid, rd_data, bf, ac);
`endif
endinterface

// File: rtl/lcd_12864b_strobe.sv
// Loadable down-counter with zero flag; times SETUP/PULSE/HOLD/GAP phases.
module lcd_12864b_strobe #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt_r;

    // Count down to zero and stop there until reloaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {W{1'b0}}) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/lcd_12864b_reader.sv
// Read-side bus controller for the 12864B parallel LCD: busy/AC and data-RAM reads.
// Define LCD_BUSY_POLL_EN to add repeated busy-flag polling with timeout.
module lcd_12864b_reader
    import lcd_12864b_pkg::*;
#(
    parameter int TAS       = DEF_TAS,
    parameter int TPW       = DEF_TPW,
    parameter int THOLD     = DEF_THOLD
`ifdef LCD_BUSY_POLL_EN
    ,
    parameter int MAX_POLLS = DEF_MAX_POLLS,
    parameter int POLL_GAP  = DEF_POLL_GAP
`endif
) (
    input  logic              clk,
    input  logic              rst,
    lcd_12864b_rd_if.slave    rd,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic              lcd_e,
    input  logic [7:0]        lcd_data_i,
    output logic              lcd_data_oe
);
`ifdef LCD_BUSY_POLL_EN
    localparam int CW = cnt_width(TAS, TPW, THOLD, POLL_GAP);
    localparam int PW = $clog2(MAX_POLLS + 1);
`else
    localparam int CW = cnt_width(TAS, TPW, THOLD, 1);
`endif

    t_rd_state       state_r, state_s;
    logic            cnt_load_s;
    logic [CW-1:0]   cnt_val_s;
    logic            cnt_zero_s;
    logic            accept_s;
    logic            capture_s;
    logic            finish_s;
    logic [7:0]      rd_data_r;
    logic            rd_valid_r;
`ifdef LCD_BUSY_POLL_EN
    logic            poll_r;
    logic            timeout_r;
    logic            again_s;
    logic [PW-1:0]   polls_r;
`endif

    lcd_12864b_strobe #(.W(CW)) u_strobe (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .zero     (cnt_zero_s)
    );

    assign accept_s  = (state_r == ST_IDLE) && rd.req;
    assign capture_s = (state_r == ST_PULSE) && cnt_zero_s;
`ifdef LCD_BUSY_POLL_EN
    // polls_r already includes the read just completed when HOLD ends.
    assign again_s   = poll_r && rd_data_r[7] && (polls_r < PW'(MAX_POLLS));
    assign finish_s  = (state_r == ST_HOLD) && cnt_zero_s && !again_s;
`else
    assign finish_s  = (state_r == ST_HOLD) && cnt_zero_s;
`endif

    // Next-state and phase-counter load decisions.
    always_comb begin
        state_s    = state_r;
        cnt_load_s = 1'b0;
        cnt_val_s  = {CW{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (rd.req) begin
                    state_s    = ST_SETUP;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = CW'(TAS - 1);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_zero_s) begin
                    state_s    = ST_PULSE;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = CW'(TPW - 1);
                end else begin
                    state_s = ST_SETUP;
                end
            end
            ST_PULSE: begin
                if (cnt_zero_s) begin
                    state_s    = ST_HOLD;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = CW'(THOLD - 1);
                end else begin
                    state_s = ST_PULSE;
                end
            end
            ST_HOLD: begin
                if (cnt_zero_s) begin
`ifdef LCD_BUSY_POLL_EN
                    if (again_s) begin
                        state_s    = ST_GAP;
                        cnt_load_s = 1'b1;
                        cnt_val_s  = CW'(POLL_GAP - 1);
                    end else begin
                        state_s = ST_IDLE;
                    end
`else
                    state_s = ST_IDLE;
`endif
                end else begin
                    state_s = ST_HOLD;
                end
            end
`ifdef LCD_BUSY_POLL_EN
            ST_GAP: begin
                if (cnt_zero_s) begin
                    state_s    = ST_SETUP;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = CW'(TAS - 1);
                end else begin
                    state_s = ST_GAP;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Pins and read data are registered from the next state so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcd_e      <= 1'b0;
            lcd_rw     <= 1'b0;
            lcd_rs     <= 1'b0;
            rd_data_r  <= 8'h00;
            rd_valid_r <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
            poll_r     <= 1'b0;
            timeout_r  <= 1'b0;
            polls_r    <= {PW{1'b0}};
`endif
        end else begin
            lcd_e      <= (state_s == ST_PULSE);
            lcd_rw     <= (state_s != ST_IDLE);
            rd_valid_r <= finish_s;
            if (capture_s) begin
                rd_data_r <= lcd_data_i;
            end
`ifdef LCD_BUSY_POLL_EN
            if (accept_s) begin
                lcd_rs    <= rd.poll ? RS_CMD : rd.rs_sel;
                poll_r    <= rd.poll;
                timeout_r <= 1'b0;
                polls_r   <= {PW{1'b0}};
            end else if (capture_s) begin
                polls_r   <= polls_r + PW'(1);
            end
            if (finish_s) begin
                timeout_r <= poll_r & rd_data_r[7];
            end
`else
            if (accept_s) begin
                lcd_rs <= rd.rs_sel;
            end
`endif
        end
    end

    assign rd.ready     = (state_r == ST_IDLE);
    assign rd.rd_valid  = rd_valid_r;
    assign rd.rd_data   = rd_data_r;
    assign rd.bf        = rd_data_r[7];
    assign rd.ac        = rd_data_r[6:0];
`ifdef LCD_BUSY_POLL_EN
    assign rd.timeout   = timeout_r;
`endif
    assign lcd_data_oe  = 1'b0;

endmodule

// File: tb/tb_lcd_12864b_reader.sv
// Self-checking bench for lcd_12864b_reader; poll scenarios run when LCD_BUSY_POLL_EN is defined.
module tb_lcd_12864b_reader;
    import lcd_12864b_pkg::*;

    localparam int TAS    = DEF_TAS;
    localparam int TPW    = DEF_TPW;
    localparam int THOLD  = DEF_THOLD;
    localparam int RD_CYC = TAS + TPW + THOLD;
`ifdef LCD_BUSY_POLL_EN
    localparam int MAX_POLLS = 5;
    localparam int POLL_GAP  = DEF_POLL_GAP;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_rs, lcd_rw, lcd_e, lcd_data_oe;
    logic [7:0] lcd_data_i = 8'h00;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] bus_q[$];

    lcd_12864b_rd_if rd ();

    lcd_12864b_reader #(
        .TAS(TAS), .TPW(TPW), .THOLD(THOLD)
`ifdef LCD_BUSY_POLL_EN
        , .MAX_POLLS(MAX_POLLS), .POLL_GAP(POLL_GAP)
`endif
    ) dut (
        .clk(clk), .rst(rst), .rd(rd),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .lcd_data_i(lcd_data_i), .lcd_data_oe(lcd_data_oe)
    );

    always #5 clk = ~clk;

    // LCD model: each E rise presents the next queued byte on the bus.
    always @(posedge lcd_e) begin
        if (bus_q.size() > 0) lcd_data_i = bus_q.pop_front();
    end

    // Issue one request and observe every cycle after acceptance until rd_valid (bounded).
    // Observation o reflects the DUT after the o-th edge following the accepting edge.
    task automatic run_read(input bit rs, input bit pl, input int inj_at,
                            output int lat, output int pulses, output int hi_min, output int hi_max,
                            output int fall0, output int rise0, output bit ctl_bad,
                            output bit ready0, output bit tmo0);
        int hi;
        bit e_prev, exp_rs;
        lat = -1; pulses = 0; hi_min = 1000; hi_max = 0; fall0 = -1; rise0 = -1;
        ctl_bad = 1'b0; ready0 = 1'b1; tmo0 = 1'b0; hi = 0; e_prev = 1'b0;
        exp_rs = rs;
        rd.req = 1'b1;
        rd.rs_sel = rs;
`ifdef LCD_BUSY_POLL_EN
        rd.poll = pl;
        if (pl) exp_rs = RS_CMD;
`endif
        @(posedge clk);
        for (int o = 0; o < 2000 && lat < 0; o++) begin
            @(negedge clk);
            if (o == 0) begin
                rd.req = 1'b0;
                ready0 = rd.ready;
`ifdef LCD_BUSY_POLL_EN
                tmo0 = rd.timeout;
`endif
            end
            if (o == inj_at) rd.req = 1'b1;
            if (o == inj_at + 1) rd.req = 1'b0;
            if (rd.rd_valid === 1'b1) begin
                lat = o;
                if (lcd_rw !== 1'b0 || lcd_e !== 1'b0 || rd.ready !== 1'b1) ctl_bad = 1'b1;
            end else if (lcd_rw !== 1'b1 || lcd_rs !== exp_rs) begin
                ctl_bad = 1'b1;
            end
            if (lcd_e && !e_prev) begin
                pulses++;
                if (rise0 < 0) rise0 = o;
            end
            if (!lcd_e && e_prev) begin
                if (fall0 < 0) fall0 = o;
                if (hi < hi_min) hi_min = hi;
                if (hi > hi_max) hi_max = hi;
            end
            hi = lcd_e ? hi + 1 : 0;
            e_prev = lcd_e;
        end
    endtask

    task automatic test_reset();
        checks++; if (rd.ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", rd.ready); end
        checks++; if (lcd_e !== 1'b0 || lcd_rw !== 1'b0 || lcd_rs !== 1'b0) begin
            errors++; $display("FAIL rst_pins: got e=%b rw=%b rs=%b expected 0 0 0", lcd_e, lcd_rw, lcd_rs); end
        checks++; if (rd.rd_valid !== 1'b0 || rd.rd_data !== 8'h00) begin
            errors++; $display("FAIL rst_data: got valid=%b data=%h expected 0 00", rd.rd_valid, rd.rd_data); end
        checks++; if (lcd_data_oe !== 1'b0) begin errors++; $display("FAIL data_oe: got %b expected 0", lcd_data_oe); end
`ifdef LCD_BUSY_POLL_EN
        checks++; if (rd.timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b expected 0", rd.timeout); end
`endif
    endtask

    task automatic test_data_read();
        int lat, pu, hmin, hmax, f0, r0;
        bit bad, rdy0, t0;
        bus_q.delete(); bus_q.push_back(8'hA5);
        run_read(RS_DATA, 1'b0, -1, lat, pu, hmin, hmax, f0, r0, bad, rdy0, t0);
        checks++; if (lat != RD_CYC) begin errors++; $display("FAIL data_latency: got %0d expected %0d", lat, RD_CYC); end
        checks++; if (pu != 1 || hmin != TPW || hmax != TPW) begin
            errors++; $display("FAIL data_e_pulse: got pulses=%0d hi=%0d..%0d expected 1 of %0d", pu, hmin, hmax, TPW); end
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL ready_fall: got %b expected 0", rdy0); end
        checks++; if (bad) begin errors++; $display("FAIL data_ctl: got rs/rw/e violation expected rs=1 rw=1 throughout"); end
        checks++; if (rd.rd_data !== 8'hA5) begin errors++; $display("FAIL data_value: got %h expected a5", rd.rd_data); end
        @(negedge clk);
        checks++; if (rd.rd_valid !== 1'b0) begin errors++; $display("FAIL valid_width: got %b expected 0", rd.rd_valid); end
    endtask

    task automatic test_status_read();
        int lat, pu, hmin, hmax, f0, r0;
        bit bad, rdy0, t0;
        bus_q.delete(); bus_q.push_back(8'h3F);
        run_read(RS_CMD, 1'b0, -1, lat, pu, hmin, hmax, f0, r0, bad, rdy0, t0);
        checks++; if (lat != RD_CYC || bad) begin errors++; $display("FAIL status_timing: got lat=%0d bad=%b expected %0d 0", lat, bad, RD_CYC); end
        checks++; if (rd.bf !== 1'b0 || rd.ac !== 7'h3F) begin
            errors++; $display("FAIL status_bf_ac: got bf=%b ac=%h expected 0 3f", rd.bf, rd.ac); end
    endtask

    task automatic test_random();
        int lat, pu, hmin, hmax, f0, r0;
        bit bad, rdy0, t0, rs;
        logic [7:0] d;
        for (int i = 0; i < 8; i++) begin
            rs = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            bus_q.delete(); bus_q.push_back(d);
            run_read(rs, 1'b0, -1, lat, pu, hmin, hmax, f0, r0, bad, rdy0, t0);
            checks++; if (lat != RD_CYC || pu != 1 || bad) begin
                errors++; $display("FAIL rand_timing[%0d]: got lat=%0d pulses=%0d bad=%b expected %0d 1 0", i, lat, pu, bad, RD_CYC); end
            checks++; if (rd.rd_data !== d || rd.bf !== d[7] || rd.ac !== d[6:0]) begin
                errors++; $display("FAIL rand_data[%0d]: got %h bf=%b ac=%h expected %h", i, rd.rd_data, rd.bf, rd.ac, d); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, pu1, hmin1, hmax1, f1, r1, lat2, pu2, hmin2, hmax2, f2, r2, gap;
        bit bad1, rdy1, t1, bad2, rdy2, t2;
        logic [7:0] d1, d2;
        d1 = 8'($urandom); d2 = 8'($urandom);
        bus_q.delete(); bus_q.push_back(d1); bus_q.push_back(d2);
        run_read(RS_DATA, 1'b0, -1, lat1, pu1, hmin1, hmax1, f1, r1, bad1, rdy1, t1);
        // Second request is raised in the rd_valid cycle itself.
        run_read(RS_CMD, 1'b0, -1, lat2, pu2, hmin2, hmax2, f2, r2, bad2, rdy2, t2);
        gap = (lat1 + 1 + r2) - f1;
        // E stays low through HOLD, the single rd_valid idle cycle and SETUP.
        checks++; if (gap != THOLD + 1 + TAS) begin errors++; $display("FAIL b2b_gap: got %0d expected %0d", gap, THOLD + 1 + TAS); end
        checks++; if (lat2 != RD_CYC || bad2 || rd.rd_data !== d2) begin
            errors++; $display("FAIL b2b_second: got lat=%0d data=%h expected %0d %h", lat2, rd.rd_data, RD_CYC, d2); end
    endtask

    task automatic test_ignored_req();
        int lat, pu, hmin, hmax, f0, r0, extra;
        bit bad, rdy0, t0;
        bus_q.delete(); bus_q.push_back(8'h6C);
        run_read(RS_DATA, 1'b0, TAS + 3, lat, pu, hmin, hmax, f0, r0, bad, rdy0, t0);
        checks++; if (lat != RD_CYC || pu != 1 || rd.rd_data !== 8'h6C) begin
            errors++; $display("FAIL ign_read: got lat=%0d pulses=%0d data=%h expected %0d 1 6c", lat, pu, rd.rd_data, RD_CYC); end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (lcd_e !== 1'b0 || rd.ready !== 1'b1 || rd.rd_valid !== 1'b0) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL ign_no_access: got %0d active cycles expected 0", extra); end
    endtask

    task automatic test_reset_mid();
        int act;
        bus_q.delete(); bus_q.push_back(8'h5A);
        rd.req = 1'b1; rd.rs_sel = RS_DATA;
`ifdef LCD_BUSY_POLL_EN
        rd.poll = 1'b0;
`endif
        @(posedge clk); @(negedge clk);
        rd.req = 1'b0;
        for (int i = 0; i < 50 && lcd_e !== 1'b1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++; if (lcd_e !== 1'b1) begin errors++; $display("FAIL mid_pulse: got e=%b expected 1", lcd_e); end
        rst = 1'b1;
        #1;
        checks++; if (lcd_e !== 1'b0 || rd.ready !== 1'b1) begin
            errors++; $display("FAIL rst_abort: got e=%b ready=%b expected 0 1", lcd_e, rd.ready); end
        checks++; if (rd.rd_valid !== 1'b0 || rd.rd_data !== 8'h00) begin
            errors++; $display("FAIL rst_abort_data: got valid=%b data=%h expected 0 00", rd.rd_valid, rd.rd_data); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        act = 0;
        repeat (30) begin
            @(negedge clk);
            if (rd.rd_valid !== 1'b0 || lcd_e !== 1'b0) act++;
        end
        checks++; if (act != 0) begin errors++; $display("FAIL rst_no_valid: got %0d active cycles expected 0", act); end
    endtask

`ifdef LCD_BUSY_POLL_EN
    task automatic test_poll();
        int lat, pu, hmin, hmax, f0, r0, nbusy, n, exp_lat;
        bit bad, rdy0, t0;
        logic [7:0] fin;
        for (int t = 0; t < 3; t++) begin
            nbusy = (t == 0) ? 3 : $urandom_range(0, MAX_POLLS - 1);
            bus_q.delete();
            for (int i = 0; i < nbusy; i++) bus_q.push_back((t == 0) ? 8'h80 : {1'b1, 7'($urandom)});
            fin = (t == 0) ? 8'h12 : {1'b0, 7'($urandom)};
            bus_q.push_back(fin);
            n = nbusy + 1;
            exp_lat = n * RD_CYC + (n - 1) * POLL_GAP;
            run_read(1'($urandom_range(0, 1)), 1'b1, -1, lat, pu, hmin, hmax, f0, r0, bad, rdy0, t0);
            checks++; if (pu != n || lat != exp_lat) begin
                errors++; $display("FAIL poll_seq[%0d]: got pulses=%0d lat=%0d expected %0d %0d", t, pu, lat, n, exp_lat); end
            checks++; if (rd.rd_data !== fin || rd.timeout !== 1'b0 || bad) begin
                errors++; $display("FAIL poll_result[%0d]: got data=%h tmo=%b bad=%b expected %h 0 0", t, rd.rd_data, rd.timeout, bad, fin); end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        int lat, pu, hmin, hmax, f0, r0, exp_lat;
        bit bad, rdy0, t0;
        logic [7:0] seq [MAX_POLLS + 2];
        bus_q.delete();
        for (int i = 0; i < MAX_POLLS + 2; i++) begin
            seq[i] = {1'b1, 7'($urandom)};
            bus_q.push_back(seq[i]);
        end
        exp_lat = MAX_POLLS * RD_CYC + (MAX_POLLS - 1) * POLL_GAP;
        run_read(RS_CMD, 1'b1, -1, lat, pu, hmin, hmax, f0, r0, bad, rdy0, t0);
        checks++; if (pu != MAX_POLLS || lat != exp_lat) begin
            errors++; $display("FAIL tmo_seq: got pulses=%0d lat=%0d expected %0d %0d", pu, lat, MAX_POLLS, exp_lat); end
        checks++; if (rd.timeout !== 1'b1 || rd.rd_data !== seq[MAX_POLLS - 1]) begin
            errors++; $display("FAIL tmo_flag: got tmo=%b data=%h expected 1 %h", rd.timeout, rd.rd_data, seq[MAX_POLLS - 1]); end
        repeat (2) @(negedge clk);
        bus_q.delete(); bus_q.push_back(8'h05);
        run_read(RS_DATA, 1'b0, -1, lat, pu, hmin, hmax, f0, r0, bad, rdy0, t0);
        checks++; if (t0 !== 1'b0 || rd.timeout !== 1'b0 || pu != 1) begin
            errors++; $display("FAIL tmo_clear: got tmo_at_accept=%b tmo_end=%b pulses=%0d expected 0 0 1", t0, rd.timeout, pu); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        rd.req = 1'b0;
        rd.rs_sel = 1'b0;
`ifdef LCD_BUSY_POLL_EN
        rd.poll = 1'b0;
`endif
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_data_read();
        test_status_read();
        test_random();
        repeat (2) @(negedge clk);
        test_back_to_back();
        repeat (2) @(negedge clk);
        test_ignored_req();
        test_reset_mid();
`ifdef LCD_BUSY_POLL_EN
        test_poll();
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
